tx_serializer: RTL and testbench

- 10-bit parallel-in/serial-out stage, the direct downstream consumer of the common clocking block; runs entirely on the 5 GHz bit-rate clock.
- Takes 8b/10b-encoded symbols over a valid/ready handshake, buffers one symbol, and shifts symbols out one bit per clock.
- Generates its own symbol-boundary strobe aligned to the serial stream, so it does not need the divided clocks.
- Inserts an idle symbol on underrun, drives electrical idle (0) when disabled, and supports per-symbol polarity inversion.

---
 rtl/tx_phy_pkg.sv | 18 +
 rtl/tx_sym_buf.sv | 46 ++++
 rtl/tx_serializer.sv | 117 +++++++++++
 tb/tb_tx_serializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_phy_pkg.sv
// rtl/tx_phy_pkg.sv - shared constants and types for the serial transmit path
package tx_phy_pkg;

    localparam int SYM_W     = 10;
    localparam int BIT_CNT_W = 4;

    // K28.5 with negative running disparity, bit 0 ('a') first on the line
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;

    // Index of the final bit of a symbol; the reload decision is taken here
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SYM_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_e;

endpackage

// File: rtl/tx_sym_buf.sv
// rtl/tx_sym_buf.sv - one-entry symbol holding register with valid/ready handshake
module tx_sym_buf #(
    parameter int SYM_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SYM_W-1:0] sym_tdata_i,
    input  logic             sym_tvalid_i,
    output logic             sym_tready_o,
    input  logic             load_i,
    output logic [SYM_W-1:0] buf_data_o,
    output logic             buf_full_o
);

    logic [SYM_W-1:0] data_q;
    logic             full_q;
    logic             full_d;
    logic             xfer;

    // A load frees the entry in the same cycle, so a new symbol can be taken
    // while the old one moves into the shifter.
    assign sym_tready_o = !full_q || load_i;
    assign xfer         = sym_tvalid_i && sym_tready_o;

    // Next fullness: a write keeps it full even when a load drains it
    always_comb begin
        full_d = full_q;
        if (load_i) full_d = 1'b0;
        if (xfer)   full_d = 1'b1;
    end

    // Holding register and occupancy flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (xfer) data_q <= sym_tdata_i;
        end
    end

    assign buf_data_o = data_q;
    assign buf_full_o = full_q;

endmodule

// File: rtl/tx_serializer.sv
// rtl/tx_serializer.sv - 10-bit parallel-in/serial-out stage on the bit-rate clock
module tx_serializer #(
    parameter int               SYM_W       = tx_phy_pkg::SYM_W,
    parameter logic [SYM_W-1:0] IDLE_SYMBOL = tx_phy_pkg::K28_5_RDN
) (
    input  logic             Bit_Rate_Clk,
    input  logic             Rst,
    input  logic [SYM_W-1:0] Sym_In,
    input  logic             Sym_Valid,
    output logic             Sym_Ready,
    input  logic             TX_Enable,
    input  logic             Invert_Polarity,
    input  logic             Clear_Underrun,
    output logic             TX_Out,
    output logic             Sym_Strobe,
    output logic             Underrun
);

    import tx_phy_pkg::*;

    tx_state_e              state_q;
    logic [SYM_W-1:0]       shift_q;
    logic [BIT_CNT_W-1:0]   cnt_q;
    logic                   strobe_q;
    logic                   underrun_q;
    logic                   underrun_d;

    logic                   load_now;
    logic                   buf_full;
    logic [SYM_W-1:0]       buf_data;
    logic [SYM_W-1:0]       load_val;
    logic                   underrun_set;

    // Reload at enable from idle, or at the last bit of a symbol while enabled
    always_comb begin
        load_now = 1'b0;
        if (TX_Enable) begin
            if (state_q == IDLE)                          load_now = 1'b1;
            else if (state_q == SHIFT && cnt_q == LAST_BIT) load_now = 1'b1;
        end
    end

    tx_sym_buf #(
        .SYM_W (SYM_W)
    ) u_buf (
        .clk_i        (Bit_Rate_Clk),
        .rst_ni       (Rst),
        .sym_tdata_i  (Sym_In),
        .sym_tvalid_i (Sym_Valid),
        .sym_tready_o (Sym_Ready),
        .load_i       (load_now),
        .buf_data_o   (buf_data),
        .buf_full_o   (buf_full)
    );

    // Polarity is applied once, at load, so a mid-symbol change waits for the next one
    assign load_val     = (buf_full ? buf_data : IDLE_SYMBOL) ^ {SYM_W{Invert_Polarity}};
    assign underrun_set = load_now && !buf_full;

    // Sticky underrun flag; a substitution in the same cycle beats the clear
    always_comb begin
        underrun_d = underrun_q;
        if (Clear_Underrun) underrun_d = 1'b0;
        if (underrun_set)   underrun_d = 1'b1;
    end

    // Control FSM, bit counter and shifter; bit 0 of shift_q is the line bit
    always_ff @(posedge Bit_Rate_Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            strobe_q   <= 1'b0;
            underrun_q <= underrun_d;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    shift_q <= '0;
                    if (load_now) begin
                        shift_q  <= load_val;
                        strobe_q <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_q <= '0;
                        if (load_now) begin
                            shift_q  <= load_val;
                            strobe_q <= 1'b1;
                        end else begin
                            // Disable only takes effect on a symbol boundary
                            shift_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    shift_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign TX_Out     = shift_q[0];
    assign Sym_Strobe = strobe_q;
    assign Underrun   = underrun_q;

endmodule

// File: tb/tb_tx_serializer.sv
// tb/tb_tx_serializer.sv - directed self-checking bench for tx_serializer
module tb_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sym_in = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       tx_en = 1'b0;
    logic       inv = 1'b0;
    logic       clr = 1'b0;
    logic       tx_out;
    logic       strobe;
    logic       underrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tx_serializer dut (
        .Bit_Rate_Clk    (clk),
        .Rst             (rst_n),
        .Sym_In          (sym_in),
        .Sym_Valid       (sym_valid),
        .Sym_Ready       (sym_ready),
        .TX_Enable       (tx_en),
        .Invert_Polarity (inv),
        .Clear_Underrun  (clr),
        .TX_Out          (tx_out),
        .Sym_Strobe      (strobe),
        .Underrun        (underrun)
    );

    typedef struct {
        logic       v;
        logic [9:0] sym;
        logic       en;
        logic       tx;
        logic       st;
        logic       ur;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [9:0] s, input logic en,
                       input logic tx, input logic st, input logic ur, input logic rdy);
        vec_t r;
        r.v = v; r.sym = s; r.en = en; r.tx = tx; r.st = st; r.ur = ur; r.rdy = rdy;
        tbl.push_back(r);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_syms [5];
        logic [9:0] src [3];
        logic [9:0] cur;
        int idx;
        int n;

        // ---------------- reset with toggling inputs ----------------
        for (int c = 0; c < 4; c++) begin
            sym_valid = 1'b1;
            sym_in    = (c % 2 == 0) ? 10'h0F3 : 10'h30C;
            tx_en     = 1'b1;
            inv       = c[0];
            clr       = 1'b0;
            @(negedge clk);
            check($sformatf("rst_tx c%0d", c), 32'(tx_out), 0);
            check($sformatf("rst_strobe c%0d", c), 32'(strobe), 0);
            check($sformatf("rst_underrun c%0d", c), 32'(underrun), 0);
            next_cycle();
        end
        sym_valid = 1'b0; tx_en = 1'b0; inv = 1'b0; sym_in = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(sym_ready), 1);
        check("tx_after_reset", 32'(tx_out), 0);
        next_cycle();

        // ---------------- single symbol, table driven ----------------
        // enable held for one cycle only: the symbol still completes
        add(1, 10'h0F3, 0,  0, 0, 0, 1);
        add(0, 10'h000, 1,  0, 0, 0, 1);
        add(0, 10'h000, 0,  1, 1, 0, 1);
        add(0, 10'h000, 0,  1, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        add(0, 10'h000, 0,  1, 0, 0, 1);
        add(0, 10'h000, 0,  1, 0, 0, 1);
        add(0, 10'h000, 0,  1, 0, 0, 1);
        add(0, 10'h000, 0,  1, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        add(0, 10'h000, 0,  0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            sym_valid = tbl[i].v;
            sym_in    = tbl[i].sym;
            tx_en     = tbl[i].en;
            @(negedge clk);
            check($sformatf("single_tx r%0d", i), 32'(tx_out), 32'(tbl[i].tx));
            check($sformatf("single_strobe r%0d", i), 32'(strobe), 32'(tbl[i].st));
            check($sformatf("single_underrun r%0d", i), 32'(underrun), 32'(tbl[i].ur));
            check($sformatf("single_ready r%0d", i), 32'(sym_ready), 32'(tbl[i].rdy));
            next_cycle();
        end
        sym_valid = 1'b0;

        // ---------------- streaming then underrun / clear ----------------
        src[0] = 10'h0F3; src[1] = 10'h30C; src[2] = 10'h2AA;
        exp_syms[0] = 10'h0F3; exp_syms[1] = 10'h30C; exp_syms[2] = 10'h2AA;
        exp_syms[3] = 10'h17C; exp_syms[4] = 10'h17C;
        idx = 0;
        for (int c = 0; c < 55; c++) begin
            n = c - 2;
            sym_valid = (idx < 3);
            sym_in    = (idx < 3) ? src[idx] : 10'h000;
            tx_en     = (c >= 1) && (n < 43);
            clr       = (n == 39) || (n == 42);
            @(negedge clk);
            if (n < 0) begin
                check($sformatf("stream_pre_tx c%0d", c), 32'(tx_out), 0);
            end else if (n < 50) begin
                cur = exp_syms[n / 10];
                check($sformatf("stream_tx n%0d", n), 32'(tx_out), 32'(cur[n % 10]));
                check($sformatf("stream_strobe n%0d", n), 32'(strobe), 32'(n % 10 == 0));
                check($sformatf("stream_underrun n%0d", n), 32'(underrun),
                      32'((n >= 30) && (n <= 42)));
            end else begin
                check($sformatf("stream_idle_tx n%0d", n), 32'(tx_out), 0);
                check($sformatf("stream_idle_strobe n%0d", n), 32'(strobe), 0);
            end
            if (sym_valid && sym_ready) idx++;
            next_cycle();
        end
        check("stream_all_accepted", 32'(idx), 3);
        sym_valid = 1'b0; tx_en = 1'b0; clr = 1'b0;

        // ---------------- polarity change mid-symbol, disable at bit 3 ----------------
        exp_syms[0] = 10'h0F3; exp_syms[1] = 10'h30C;
        for (int c = 0; c < 25; c++) begin
            n = c - 2;
            sym_valid = (c < 2);
            sym_in    = 10'h0F3;
            tx_en     = (c >= 1) && (n < 13);
            inv       = (n >= 4) && (n <= 9);
            @(negedge clk);
            if (n < 0) begin
                check($sformatf("pol_pre_tx c%0d", c), 32'(tx_out), 0);
            end else if (n < 20) begin
                cur = exp_syms[n / 10];
                check($sformatf("pol_tx n%0d", n), 32'(tx_out), 32'(cur[n % 10]));
                check($sformatf("pol_strobe n%0d", n), 32'(strobe), 32'(n % 10 == 0));
            end else begin
                check($sformatf("dis_idle_tx n%0d", n), 32'(tx_out), 0);
                check($sformatf("dis_idle_strobe n%0d", n), 32'(strobe), 0);
                check($sformatf("dis_idle_underrun n%0d", n), 32'(underrun), 0);
            end
            next_cycle();
        end
        sym_valid = 1'b0; tx_en = 1'b0; inv = 1'b0;

        // ---------------- asynchronous reset mid-symbol ----------------
        sym_valid = 1'b1; sym_in = 10'h0F3; tx_en = 1'b0;
        @(negedge clk);
        next_cycle();
        sym_valid = 1'b1; sym_in = 10'h2AA; tx_en = 1'b1;
        @(negedge clk);
        check("rstmid_ready_on_load", 32'(sym_ready), 1);
        next_cycle();
        sym_valid = 1'b0;
        cur = 10'h0F3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_tx b%0d", k), 32'(tx_out), 32'(cur[k]));
            if (k < 4) next_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_async_tx", 32'(tx_out), 0);
        check("rstmid_async_strobe", 32'(strobe), 0);
        tx_en = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        tx_en = 1'b1;
        @(negedge clk);
        check("rstmid_post_tx", 32'(tx_out), 0);
        check("rstmid_post_underrun", 32'(underrun), 0);
        next_cycle();
        tx_en = 1'b0;
        cur = 10'h17C;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_idle_sym b%0d", k), 32'(tx_out), 32'(cur[k]));
            check($sformatf("rstmid_strobe b%0d", k), 32'(strobe), 32'(k == 0));
            check($sformatf("rstmid_underrun b%0d", k), 32'(underrun), 1);
            next_cycle();
        end
        @(negedge clk);
        check("rstmid_final_tx", 32'(tx_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
